// File: rtl/channel_expander.sv
// channel_expander: rebuilds full N-channel frames from a desired-channel-only stream,
// zero-filling undesired channels, through a two-bank ping-pong frame buffer.
module channel_expander #(
  parameter int N     = 8,
  parameter int LOGN  = 3,
  parameter int WDTH  = 32,
  parameter int MWDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     desired_channels,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  input  logic             in_first,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             out_first,
  output logic             error
);
  logic [WDTH-1:0]  data_q [2][N];
  logic [MWDTH-1:0] m_q [2][N];
  logic [N-1:0]     mask_q [2];
  logic [MWDTH-1:0] fm_q [2];
  logic [1:0]       full_q;
  logic             wr_bank_q, in_frame_q, rd_bank_q;
  logic [LOGN-1:0]  wr_chan_q, rd_chan_q;
  logic [N-1:0]     mask_w_q;
  logic [MWDTH-1:0] fm_w_q;
  logic             p_nd_q, p_first_q;
  logic [WDTH-1:0]  p_data_q;
  logic [MWDTH-1:0] p_m_q;
  logic [LOGN-1:0]  lo, nxt, chan_d;
  logic [N-1:0]     mask_d;
  logic [MWDTH-1:0] fm_d;
  logic             ovf, start, cont, wr, done, in_frame_d, err_d, rd, last, sel;
  always_comb begin
    lo  = '0;
    nxt = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (desired_channels[c]) lo = LOGN'(c);
      if (mask_w_q[c] && c > int'(wr_chan_q)) nxt = LOGN'(c);
    end
  end
  // A bank only becomes full at commit, so a frame in progress never sees its own bank full.
  assign ovf        = in_nd & full_q[wr_bank_q];
  assign start      = in_nd & ~ovf & in_first & |desired_channels;
  assign cont       = in_nd & ~ovf & ~in_first & in_frame_q;
  assign wr         = start | cont;
  assign err_d      = error | ovf | (in_nd & ~ovf & (in_first ? (~|desired_channels | in_frame_q) : ~in_frame_q));
  assign mask_d     = start ? desired_channels : mask_w_q;
  assign fm_d       = start ? in_m : fm_w_q;
  assign chan_d     = start ? lo : cont ? nxt : wr_chan_q;
  assign done       = wr & (((mask_d >> chan_d) >> 1) == '0);
  assign in_frame_d = wr ? ~done : in_frame_q;
  assign rd         = full_q[rd_bank_q];
  assign last       = rd_chan_q == LOGN'(N - 1);
  assign sel        = mask_q[rd_bank_q][rd_chan_q];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      in_frame_q <= 1'b0;
      wr_chan_q  <= '0;
      mask_w_q   <= '0;
      fm_w_q     <= '0;
      rd_bank_q  <= 1'b0;
      rd_chan_q  <= '0;
      p_nd_q     <= 1'b0;
      p_first_q  <= 1'b0;
      p_data_q   <= '0;
      p_m_q      <= '0;
      out_data   <= '0;
      out_nd     <= 1'b0;
      out_m      <= '0;
      out_first  <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (wr) begin
        data_q[wr_bank_q][chan_d] <= in_data;
        m_q[wr_bank_q][chan_d]    <= in_m;
      end
      wr_chan_q  <= chan_d;
      mask_w_q   <= mask_d;
      fm_w_q     <= fm_d;
      in_frame_q <= in_frame_d;
      error      <= err_d;
      if (done) begin
        mask_q[wr_bank_q] <= mask_d;
        fm_q[wr_bank_q]   <= fm_d;
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      // Channel N-1 leaving the bank frees it; the other bank, if full, is read next cycle.
      if (rd && last) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
      rd_chan_q <= rd ? rd_chan_q + 1'b1 : rd_chan_q;
      p_nd_q    <= rd;
      if (rd) begin
        p_data_q  <= sel ? data_q[rd_bank_q][rd_chan_q] : '0;
        p_m_q     <= sel ? m_q[rd_bank_q][rd_chan_q] : fm_q[rd_bank_q];
        p_first_q <= rd_chan_q == '0;
      end
      out_nd    <= p_nd_q;
      out_first <= p_nd_q & p_first_q;
      if (p_nd_q) begin
        out_data <= p_data_q;
        out_m    <= p_m_q;
      end
    end
  end
endmodule

// File: tb/tb_channel_expander.sv
// tb_channel_expander: directed stimulus against a frame-level model of channel expansion,
// checked every cycle, plus literal expectations for each scenario.
module tb_channel_expander;
  localparam int N = 8;
  localparam int MAXE = 4096;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  desired_channels = 0;
  logic [31:0] in_data = 0;
  logic        in_nd = 0, in_m = 0, in_first = 0;
  logic [31:0] out_data;
  logic        out_nd, out_m, out_first, error;

  channel_expander #(.N(8), .LOGN(3), .WDTH(32), .MWDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .desired_channels(desired_channels),
    .in_data(in_data), .in_nd(in_nd), .in_m(in_m), .in_first(in_first),
    .out_data(out_data), .out_nd(out_nd), .out_m(out_m), .out_first(out_first),
    .error(error)
  );

  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // model: expected output per edge index, plus frame/bank bookkeeping
  bit          ev [MAXE];
  logic [31:0] ed [MAXE];
  bit          em [MAXE], ef [MAXE];
  int          rel[$];
  int          r_prev;
  bit          exp_err, inframe, fm;
  logic [7:0]  mw;
  int          cnt;
  logic [31:0] fd [N];
  bit          fdm [N];

  logic [31:0] got_d[$];
  bit          got_m[$], got_f[$];
  int          got_e[$];
  int tests = 0, fails = 0;
  logic [7:0] cur_mask = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic model_step(bit rn, bit nd, bit fi, logic [31:0] d, bit m, logic [7:0] msk, int w);
    int pos, k, st;
    if (!rn) begin
      for (int i = w; i < MAXE; i++) ev[i] = 0;
      rel.delete();
      r_prev = w;
      inframe = 0;
      exp_err = 0;
      return;
    end
    if (!nd) return;
    while (rel.size() > 0 && rel[0] < w) void'(rel.pop_front());
    if (rel.size() == 2) begin
      exp_err = 1;
      return;
    end
    if (fi) begin
      if (msk == 0) begin
        exp_err = 1;
        return;
      end
      if (inframe) exp_err = 1;
      inframe = 1;
      mw = msk;
      cnt = 0;
      fm = m;
    end else if (!inframe) begin
      exp_err = 1;
      return;
    end
    k = 0;
    pos = 0;
    for (int c = 0; c < N; c++) if (mw[c]) begin
      if (k == cnt) pos = c;
      k++;
    end
    fd[pos] = d;
    fdm[pos] = m;
    cnt++;
    if (cnt == $countones(mw)) begin
      inframe = 0;
      st = (w + 1 > r_prev + 1) ? w + 1 : r_prev + 1;
      r_prev = st + N - 1;
      rel.push_back(r_prev);
      for (int i = 0; i < N; i++) begin
        ev[st + 1 + i] = 1;
        ed[st + 1 + i] = mw[i] ? fd[i] : 32'h0;
        em[st + 1 + i] = mw[i] ? fdm[i] : fm;
        ef[st + 1 + i] = (i == 0);
      end
    end
  endtask

  task automatic step(bit rn, bit nd, bit fi, logic [31:0] d, bit m, logic [7:0] msk);
    rst_n = rn;
    in_nd = nd;
    in_first = fi;
    in_data = d;
    in_m = m;
    desired_channels = msk;
    @(posedge clk);
    #1;
    model_step(rn, nd, fi, d, m, msk, edge_n);
    #3;
    if (ev[edge_n]) begin
      chk("out_nd", out_nd, 1);
      chk("out_data", out_data, ed[edge_n]);
      chk("out_m", out_m, em[edge_n]);
      chk("out_first", out_first, ef[edge_n]);
    end else chk("out_nd_idle", out_nd, 0);
    chk("error", error, exp_err);
    if (out_nd) begin
      got_d.push_back(out_data);
      got_m.push_back(out_m);
      got_f.push_back(out_first);
      got_e.push_back(edge_n);
    end
  endtask

  task automatic send(bit fi, logic [31:0] d, bit m);
    step(1, 1, fi, d, m, cur_mask);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0, cur_mask);
  endtask

  task automatic rst1();
    step(0, 0, 0, 32'h0, 0, cur_mask);
  endtask

  initial begin
    int base, ce;
    logic [31:0] exp_d [8];
    bit exp_m [8];
    rst1();
    rst1();
    // T1: sparse mask 0x25
    cur_mask = 8'h25;
    base = got_d.size();
    send(1, 32'hA, 1);
    send(0, 32'hB, 0);
    send(0, 32'hC, 1);
    ce = edge_n;
    idle(12);
    exp_d = '{32'hA, 0, 32'hB, 0, 0, 32'hC, 0, 0};
    exp_m = '{1, 1, 0, 1, 1, 1, 1, 1};
    chk("t1_count", got_d.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", got_d[base + i], exp_d[i]);
      chk("t1_m", got_m[base + i], exp_m[i]);
      chk("t1_first", got_f[base + i], i == 0);
    end
    chk("t1_latency", got_e[base], ce + 2);
    chk("t1_error", error, 0);
    // T2: full mask, 4 back-to-back frames
    cur_mask = 8'hFF;
    base = got_d.size();
    for (int i = 0; i < 32; i++) send(i % 8 == 0, 32'h2000_0000 + i, i[0]);
    idle(20);
    chk("t2_count", got_d.size() - base, 32);
    for (int i = 0; i < 32; i++) begin
      chk("t2_data", got_d[base + i], 32'h2000_0000 + i);
      chk("t2_gap", got_e[base + i], got_e[base] + i);
      chk("t2_first", got_f[base + i], i % 8 == 0);
    end
    chk("t2_error", error, 0);
    // T3: reader stall, third frame dropped
    cur_mask = 8'h0F;
    base = got_d.size();
    for (int i = 0; i < 12; i++) send(i % 4 == 0, 32'h3000_0000 + i, 0);
    idle(24);
    chk("t3_count", got_d.size() - base, 16);
    for (int f = 0; f < 2; f++) for (int c = 0; c < 8; c++)
      chk("t3_data", got_d[base + f * 8 + c], c < 4 ? 32'h3000_0000 + f * 4 + c : 32'h0);
    chk("t3_error", error, 1);
    rst1();
    // T4: mid-frame restart
    cur_mask = 8'h07;
    base = got_d.size();
    send(1, 32'h4A0, 0);
    send(0, 32'h4A1, 0);
    send(1, 32'h4B0, 0);
    send(0, 32'h4B1, 0);
    send(0, 32'h4B2, 0);
    idle(12);
    exp_d = '{32'h4B0, 32'h4B1, 32'h4B2, 0, 0, 0, 0, 0};
    chk("t4_count", got_d.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("t4_data", got_d[base + i], exp_d[i]);
    chk("t4_error", error, 1);
    rst1();
    // T5: mask change mid-frame
    cur_mask = 8'h03;
    base = got_d.size();
    send(1, 32'h50, 0);
    cur_mask = 8'h80;
    send(0, 32'h51, 0);
    send(1, 32'h52, 1);
    idle(20);
    chk("t5_count", got_d.size() - base, 16);
    for (int i = 0; i < 8; i++) begin
      chk("t5_f0", got_d[base + i], i == 0 ? 32'h50 : i == 1 ? 32'h51 : 32'h0);
      chk("t5_f1", got_d[base + 8 + i], i == 7 ? 32'h52 : 32'h0);
      chk("t5_f1_m", got_m[base + 8 + i], 1);
    end
    chk("t5_error", error, 0);
    // T6: reset mid-output
    cur_mask = 8'hFF;
    send(0, 32'h60, 0);
    for (int i = 0; i < 8; i++) send(i == 0, 32'h6100 + i, 0);
    idle(4);
    chk("t6_pre_nd", out_nd, 1);
    rst1();
    chk("t6_rst_nd", out_nd, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_error", error, 0);
    idle(12);
    cur_mask = 8'h01;
    base = got_d.size();
    send(1, 32'h6D, 1);
    idle(12);
    chk("t6_count", got_d.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("t6_data", got_d[base + i], i == 0 ? 32'h6D : 32'h0);
    chk("t6_error", error, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
